// File: rtl/alu.sv
// 6502-style 8-bit ALU for the NES CPU datapath.
// Add-with-carry (subtract by inverting B), AND, EOR, OR, logical shift-right
// and rotate-right through carry. RES, Cout and OVFout are registered.
// Build option: define ALU_ZN_FLAGS_EN to add the registered Zout/Nout flags.
// There is no handshake. Inputs are sampled on every rising clk edge. When no
// operation enable is set, all outputs hold their previous values.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ROR_en,
    input  logic             SUM_en,
    input  logic             AND_en,
    input  logic             EOR_en,
    input  logic             OR_en,
    input  logic             SR_en,
    input  logic             INV_en,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic             Cin,
    output logic [WIDTH-1:0] RES,
    output logic             Cout,
    output logic             OVFout
`ifdef ALU_ZN_FLAGS_EN
    ,
    output logic             Zout,
    output logic             Nout
`endif
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             load;

    // Optional inversion of B, then a full-width add that keeps the carry bit.
    always_comb begin
        b_eff    = INV_en ? ~Bin : Bin;
        sum_full = {1'b0, Ain} + {1'b0, b_eff} + {{WIDTH{1'b0}}, Cin};
    end

    // Select the operation with fixed priority SUM > AND > EOR > OR > SR > ROR.
    // When nothing is selected, keep the current values.
    always_comb begin
        res_d  = res_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        load   = 1'b1;
        if (SUM_en) begin
            res_d  = sum_full[WIDTH-1:0];
            cout_d = sum_full[WIDTH];
            ovf_d  = (Ain[MSB] == b_eff[MSB]) && (sum_full[MSB] != Ain[MSB]);
        end else if (AND_en) begin
            res_d  = Ain & b_eff;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
        end else if (EOR_en) begin
            res_d  = Ain ^ b_eff;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
        end else if (OR_en) begin
            res_d  = Ain | b_eff;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
        end else if (SR_en) begin
            res_d  = {1'b0, Ain[WIDTH-1:1]};
            cout_d = Ain[0];
            ovf_d  = 1'b0;
        end else if (ROR_en) begin
            res_d  = {Cin, Ain[WIDTH-1:1]};
            cout_d = Ain[0];
            ovf_d  = 1'b0;
        end else begin
            load   = 1'b0;
        end
    end

    // Output registers. Reset is asynchronous and overrides any capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            res_q  <= res_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign RES    = res_q;
    assign Cout   = cout_q;
    assign OVFout = ovf_q;

`ifdef ALU_ZN_FLAGS_EN
    logic zero_q, zero_d;
    logic neg_q, neg_d;

    // Zero and negative flags follow the newly captured result. They hold
    // together with RES when no operation is selected.
    always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        if (load) begin
            zero_d = (res_d == '0);
            neg_d  = res_d[MSB];
        end
    end

    // Flag registers. They share the asynchronous reset with RES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign Zout = zero_q;
    assign Nout = neg_q;
`else
    // Without the flag outputs, the load indication has no consumer.
    logic unused_load;
    assign unused_load = load;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/hold/priority
// sequences, and randomized operations checked against a behavioural model.
module tb_alu;

    logic       clk;
    logic       rst;
    logic       ROR_en, SUM_en, AND_en, EOR_en, OR_en, SR_en, INV_en;
    logic [7:0] Ain, Bin;
    logic       Cin;
    logic [7:0] RES;
    logic       Cout, OVFout;
`ifdef ALU_ZN_FLAGS_EN
    logic       Zout, Nout;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Expected state. After reset RES is zero but Zout is also zero, so the
    // flags are tracked separately instead of being derived from RES.
    logic [7:0] m_res;
    logic       m_c, m_v, m_z, m_n;

    // Scoreboard queue of expected {Cout, OVFout, RES} words.
    logic [9:0] exp_q[$];

    alu #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .ROR_en(ROR_en), .SUM_en(SUM_en), .AND_en(AND_en), .EOR_en(EOR_en),
        .OR_en(OR_en), .SR_en(SR_en), .INV_en(INV_en),
        .Ain(Ain), .Bin(Bin), .Cin(Cin),
        .RES(RES), .Cout(Cout), .OVFout(OVFout)
`ifdef ALU_ZN_FLAGS_EN
        , .Zout(Zout), .Nout(Nout)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Enable vector bit order: {SUM, AND, EOR, OR, SR, ROR}.
    typedef struct {
        string      name;
        logic [5:0] en;
        logic       inv;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] res;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs[$];

    // ---------------- driver ----------------
    task automatic drive(input logic [5:0] en, input logic inv,
                         input logic [7:0] a, input logic [7:0] b, input logic cin);
        {SUM_en, AND_en, EOR_en, OR_en, SR_en, ROR_en} = en;
        INV_en = inv;
        Ain    = a;
        Bin    = b;
        Cin    = cin;
    endtask

    // Drive one operation, clock it in, and sample 1 time unit after the edge.
    task automatic apply(input logic [5:0] en, input logic inv,
                         input logic [7:0] a, input logic [7:0] b, input logic cin);
        drive(en, inv, a, b, cin);
        @(posedge clk);
        #1;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [7:0] res,
                         input logic c, input logic v);
        n_checks++;
        if (RES !== res || Cout !== c || OVFout !== v) begin
            n_fail++;
            $display("FAIL %s: got RES=%02h Cout=%b OVF=%b, expected RES=%02h Cout=%b OVF=%b",
                     name, RES, Cout, OVFout, res, c, v);
        end
`ifdef ALU_ZN_FLAGS_EN
        n_checks++;
        if (Zout !== m_z || Nout !== m_n) begin
            n_fail++;
            $display("FAIL %s_zn: got Z=%b N=%b, expected Z=%b N=%b",
                     name, Zout, Nout, m_z, m_n);
        end
`endif
    endtask

    // ---------------- reference model ----------------
    // Computed with integer arithmetic from the operation definitions:
    // carry is "unsigned sum exceeds 255", overflow is "signed sum leaves
    // -128..127".
    task automatic model(input logic [5:0] en, input logic inv,
                         input logic [7:0] a, input logic [7:0] b, input logic cin);
        int ai, bi, ci, s, sa, sb, sv, r;
        ai = int'(a);
        bi = inv ? 255 - int'(b) : int'(b);
        ci = int'(cin);
        r  = -1;
        if (en[5]) begin
            s   = ai + bi + ci;
            r   = s % 256;
            m_c = (s > 255);
            sa  = (ai >= 128) ? ai - 256 : ai;
            sb  = (bi >= 128) ? bi - 256 : bi;
            sv  = sa + sb + ci;
            m_v = (sv > 127) || (sv < -128);
        end else if (en[4] || en[3] || en[2]) begin
            if (en[4])      r = ai & bi;
            else if (en[3]) r = ai ^ bi;
            else            r = ai | bi;
            m_c = 1'b0;
            m_v = 1'b0;
        end else if (en[1]) begin
            r   = ai / 2;
            m_c = (ai % 2) == 1;
            m_v = 1'b0;
        end else if (en[0]) begin
            r   = ai / 2 + 128 * ci;
            m_c = (ai % 2) == 1;
            m_v = 1'b0;
        end
        if (r >= 0) begin
            m_res = 8'(r);
            m_z   = (r == 0);
            m_n   = (r >= 128);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] w;
        logic [5:0] en;
        logic [7:0] ra, rb;
        logic       rinv, rcin;
        int         pick;
        int         hold_res;

        drive(6'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        m_res = 8'h00; m_c = 1'b0; m_v = 1'b0; m_z = 1'b0; m_n = 1'b0;

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_init", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // Directed vectors with hand-derived expected values.
        vecs.push_back('{"add_7f_7f_c1", 6'b100000, 1'b0, 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1});
        vecs.push_back('{"add_7f_01",    6'b100000, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{"sub_01_01",    6'b100000, 1'b1, 8'h01, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{"sub_80_01",    6'b100000, 1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1});
        vecs.push_back('{"sub_00_01",    6'b100000, 1'b1, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{"sub_7f_ff",    6'b100000, 1'b1, 8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{"add_ff_01",    6'b100000, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{"and",          6'b010000, 1'b0, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0});
        vecs.push_back('{"eor",          6'b001000, 1'b0, 8'hF0, 8'h3C, 1'b1, 8'hCC, 1'b0, 1'b0});
        vecs.push_back('{"or",           6'b000100, 1'b0, 8'hF0, 8'h3C, 1'b1, 8'hFC, 1'b0, 1'b0});
        vecs.push_back('{"and_inv",      6'b010000, 1'b1, 8'hF0, 8'h3C, 1'b0, 8'hC0, 1'b0, 1'b0});
        vecs.push_back('{"eor_inv",      6'b001000, 1'b1, 8'hF0, 8'h3C, 1'b0, 8'h33, 1'b0, 1'b0});
        vecs.push_back('{"sr_81",        6'b000010, 1'b0, 8'h81, 8'h00, 1'b1, 8'h40, 1'b1, 1'b0});
        vecs.push_back('{"ror_81_c1",    6'b000001, 1'b0, 8'h81, 8'h00, 1'b1, 8'hC0, 1'b1, 1'b0});
        vecs.push_back('{"ror_81_c0",    6'b000001, 1'b0, 8'h81, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0});
        vecs.push_back('{"ror_02_c0",    6'b000001, 1'b0, 8'h02, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{"sum_and_prio", 6'b110000, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{"eor_or_prio",  6'b001100, 1'b0, 8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b0, 1'b0});
        vecs.push_back('{"sr_ror_prio",  6'b000011, 1'b0, 8'h81, 8'h00, 1'b1, 8'h40, 1'b1, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].en, vecs[i].inv, vecs[i].a, vecs[i].b, vecs[i].cin);
            m_res = vecs[i].res; m_c = vecs[i].c; m_v = vecs[i].v;
            m_z = (vecs[i].res == 8'h00); m_n = vecs[i].res[7];
            check(vecs[i].name, vecs[i].res, vecs[i].c, vecs[i].v);
        end

        // Hold: load a known value, then three idle cycles with changing operands.
        apply(6'b100000, 1'b0, 8'h7F, 8'h01, 1'b0);
        m_res = 8'h80; m_c = 1'b0; m_v = 1'b1; m_z = 1'b0; m_n = 1'b1;
        check("hold_load", 8'h80, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply(6'b000000, 1'b1, 8'(i * 37 + 5), 8'hA5, 1'b1);
            check($sformatf("hold_%0d", i), 8'h80, 1'b0, 1'b1);
        end

`ifdef ALU_ZN_FLAGS_EN
        // Zero-result subtract sets Z and clears N.
        apply(6'b100000, 1'b1, 8'h01, 8'h01, 1'b1);
        m_res = 8'h00; m_c = 1'b1; m_v = 1'b0; m_z = 1'b1; m_n = 1'b0;
        check("zn_zero", 8'h00, 1'b1, 1'b0);
`endif

        // Asynchronous reset mid-cycle, away from any clock edge.
        apply(6'b100000, 1'b0, 8'h7F, 8'h7F, 1'b1);
        m_res = 8'hFF; m_c = 1'b0; m_v = 1'b1; m_z = 1'b0; m_n = 1'b1;
        check("pre_async_rst", 8'hFF, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        m_res = 8'h00; m_c = 1'b0; m_v = 1'b0; m_z = 1'b0; m_n = 1'b0;
        check("async_rst", 8'h00, 1'b0, 1'b0);
        // Reset held across an edge with an operation requested.
        drive(6'b100000, 1'b0, 8'h7F, 8'h7F, 1'b1);
        @(posedge clk);
        #1;
        check("rst_overrides", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized operations against the model, via the expected queue.
        hold_res = 0;
        for (int i = 0; i < 400; i++) begin
            pick = $urandom_range(0, 9);
            if (pick < 6)      en = 6'(1 << pick);
            else if (pick < 8) en = 6'($urandom_range(0, 63));
            else               en = 6'b0;
            if (en == 6'b0) hold_res++;
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rinv = 1'($urandom_range(0, 1));
            rcin = 1'($urandom_range(0, 1));
            model(en, rinv, ra, rb, rcin);
            exp_q.push_back({m_c, m_v, m_res});
            apply(en, rinv, ra, rb, rcin);
            w = exp_q.pop_front();
            check($sformatf("rand_%0d_en%06b", i, en), w[7:0], w[9], w[8]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 8-bit 6502-style arithmetic/logic unit for the NES CPU datapath.
- Performs add-with-carry (subtract via B inversion), AND, EOR, OR, shift-right and rotate-right on operands Ain/Bin.
- Results, carry and overflow are captured in output registers on the clock edge.
- Sits between the CPU register file/input latches and the adder-hold register/flag logic.

Parameters:
- WIDTH, 8, operand and result width in bits; the CPU uses only 8.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous active-high reset
- ROR_en  input  1  select rotate-right of Ain through carry
- SUM_en  input  1  select Ain + B' + Cin
- AND_en  input  1  select Ain & B'
- EOR_en  input  1  select Ain ^ B'
- OR_en  input  1  select Ain | B'
- SR_en  input  1  select logical shift-right of Ain
- INV_en  input  1  B' = ~Bin when 1, else B' = Bin
- Ain  input  WIDTH  operand A
- Bin  input  WIDTH  operand B
- Cin  input  1  carry in
- RES  output  WIDTH  registered result
- Cout  output  1  registered carry out
- OVFout  output  1  registered signed overflow

Behaviour:
- Single clock domain. Reset is asynchronous and active-high.
- Reset clears RES, Cout and OVFout to 0. Reset asserted mid-operation overrides any capture.
- Latency: inputs are sampled at the rising edge of clk; outputs are valid after that same edge (1 cycle). No handshake is used.
- B' = INV_en ? ~Bin : Bin. B' applies to SUM, AND, EOR and OR.
- SUM:
  - {Cout, RES} = Ain + B' + Cin, computed at WIDTH+1 bits.
  - OVFout = (Ain[MSB] == B'[MSB]) && (RES[MSB] != Ain[MSB]).
- AND/EOR/OR: RES = bitwise result. Cout = 0, OVFout = 0.
- SR: RES = {0, Ain[WIDTH-1:1]}; Cout = Ain[0]; OVFout = 0.
- ROR: RES = {Cin, Ain[WIDTH-1:1]}; Cout = Ain[0]; OVFout = 0.
- Enables are expected to be one-hot. If several are asserted, fixed priority applies: SUM > AND > EOR > OR > SR > ROR.
- No enable asserted: RES, Cout and OVFout hold their previous values.
- Wrap-around: the sum is modulo 2^WIDTH and the carry is reported in Cout. No saturation. No decimal mode.

Optional Feature:
- Macro: ALU_ZN_FLAGS_EN.
- Defined:
  - Adds output ports Zout (1) and Nout (1).
  - Zout = (next RES == 0); Nout = next RES[MSB].
  - Both are registered alongside RES, reset to 0, and hold when no enable is asserted.
- Undefined: the ports and logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> RES=0x00, Cout=0, OVFout=0 immediately, with no clock edge needed.
- SUM, INV_en=0:
  - Ain=0x7F, Bin=0x7F, Cin=1 -> RES=0xFF, Cout=0, OVFout=1 after one edge.
  - Ain=0x7F, Bin=0x01, Cin=0 -> RES=0x80, Cout=0, OVFout=1.
- SUM, INV_en=1 (subtract):
  - Ain=0x01, Bin=0x01, Cin=1 -> RES=0x00, Cout=1, OVFout=0.
  - Ain=0x80, Bin=0x01, Cin=1 -> RES=0x7F, Cout=1, OVFout=1.
  - Ain=0x00, Bin=0x01, Cin=1 -> RES=0xFF, Cout=0, OVFout=0.
  - Ain=0x7F, Bin=0xFF, Cin=1 -> RES=0x80, Cout=0, OVFout=1.
- Logic ops, Ain=0xF0, Bin=0x3C, INV_en=0:
  - AND -> RES=0x30.
  - EOR -> RES=0xCC.
  - OR -> RES=0xFC.
  - In all three, Cout=0, OVFout=0.
  - AND with INV_en=1 -> RES=0xC0.
- Shifts, Ain=0x81:
  - SR -> RES=0x40, Cout=1.
  - ROR with Cin=1 -> RES=0xC0, Cout=1.
  - ROR with Cin=0 -> RES=0x40, Cout=1.
- Control cases:
  - All enables 0 for 3 cycles -> outputs hold their last values.
  - SUM_en and AND_en both asserted -> SUM result is captured.
  - With ALU_ZN_FLAGS_EN defined, Ain=0x01, Bin=0x01, INV_en=1, Cin=1 -> Zout=1, Nout=0.
